// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the pipelined ALU control stage: ALUop codes,
// LEGv8 R/I opcode patterns, ALU operation encodings and FSM states.
package alu_ctrl_pkg;

  localparam int OPCODE_W = 11;
  localparam int OPER_W   = 4;
  localparam int IOPC_W   = 10;

  // Main-control ALUop encodings
  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // R-format opcodes (instruction[31:21])
  localparam logic [OPCODE_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OPC_ORR = 11'b10101010000;
  localparam logic [OPCODE_W-1:0] OPC_EOR = 11'b11001010000;
  localparam logic [OPCODE_W-1:0] OPC_LSL = 11'b11010011011;
  localparam logic [OPCODE_W-1:0] OPC_LSR = 11'b11010011010;
  localparam logic [OPCODE_W-1:0] OPC_MUL = 11'b10011011000;

  // I-format opcodes (instruction[31:22], i.e. opcode_field[10:1])
  localparam logic [IOPC_W-1:0] OPC_ADDI = 10'b1001000100;
  localparam logic [IOPC_W-1:0] OPC_SUBI = 10'b1101000100;
  localparam logic [IOPC_W-1:0] OPC_ANDI = 10'b1001001000;
  localparam logic [IOPC_W-1:0] OPC_ORRI = 10'b1011001000;

  // ALU operation encodings
  localparam logic [OPER_W-1:0] OP_AND     = 4'b0000;
  localparam logic [OPER_W-1:0] OP_ORR     = 4'b0001;
  localparam logic [OPER_W-1:0] OP_ADD     = 4'b0010;
  localparam logic [OPER_W-1:0] OP_EOR     = 4'b0011;
  localparam logic [OPER_W-1:0] OP_SUB     = 4'b0110;
  localparam logic [OPER_W-1:0] OP_PASSB   = 4'b0111;
  localparam logic [OPER_W-1:0] OP_LSL     = 4'b1000;
  localparam logic [OPER_W-1:0] OP_LSR     = 4'b1001;
  localparam logic [OPER_W-1:0] OP_MUL     = 4'b1010;
  localparam logic [OPER_W-1:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    MUL_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {ALUop, opcode field} into an ALU operation,
// an illegal flag and a MUL marker used by the stage to pick its latency.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0]          alu_op,
  input  logic [OPCODE_W-1:0] opcode_field,
  output logic [OPER_W-1:0]   operation,
  output logic                illegal,
  output logic                is_mul
);

  logic [IOPC_W-1:0] iopc;
  assign iopc = opcode_field[OPCODE_W-1:1];

  // Full decode with defaults first so every path drives every output
  always_comb begin
    operation = OP_ILLEGAL;
    illegal   = 1'b0;
    is_mul    = 1'b0;
    case (alu_op)
      ALUOP_LDST: operation = OP_ADD;
      ALUOP_CBZ:  operation = OP_PASSB;
      ALUOP_RTYPE: begin
        case (opcode_field)
          OPC_ADD: operation = OP_ADD;
          OPC_SUB: operation = OP_SUB;
          OPC_AND: operation = OP_AND;
          OPC_ORR: operation = OP_ORR;
          OPC_EOR: operation = OP_EOR;
          OPC_LSL: operation = OP_LSL;
          OPC_LSR: operation = OP_LSR;
          OPC_MUL: begin
            operation = OP_MUL;
            is_mul    = 1'b1;
          end
          default: begin
            operation = OP_ILLEGAL;
            illegal   = 1'b1;
          end
        endcase
      end
      default: begin
        // I-type: the low opcode bit belongs to the immediate
        case (iopc)
          OPC_ADDI: operation = OP_ADD;
          OPC_SUBI: operation = OP_SUB;
          OPC_ANDI: operation = OP_AND;
          OPC_ORRI: operation = OP_ORR;
          default: begin
            operation = OP_ILLEGAL;
            illegal   = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered, handshaked ALU control stage between ID and EX.
// Holds one decoded op; MUL holds the stage busy for MUL_CYCLES edges.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = alu_ctrl_pkg::OPCODE_W,
  parameter int OPER_W     = alu_ctrl_pkg::OPER_W,
  parameter int MUL_CYCLES = 4,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           alu_op,
  input  logic [OPCODE_W-1:0]  opcode_field,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPER_W-1:0]    alu_operation,
  output logic                 illegal,
  output logic                 busy,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam bit MUL_MULTI = (MUL_CYCLES > 1);

  state_e                state_q;
  logic [CNT_W-1:0]      count_q;
  logic [OPER_W-1:0]     op_q;
  logic                  illegal_q;
  logic [ILL_CNT_W-1:0]  ill_cnt_q;

  logic [OPER_W-1:0]     dec_op;
  logic                  dec_illegal;
  logic                  dec_mul;
  logic                  accept;

  alu_ctrl_decode u_decode (
    .alu_op       (alu_op),
    .opcode_field (opcode_field),
    .operation    (dec_op),
    .illegal      (dec_illegal),
    .is_mul       (dec_mul)
  );

  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == VALID) && out_ready));
  assign accept   = in_valid && in_ready;

  assign out_valid     = (state_q == VALID);
  assign busy          = (state_q == MUL_WAIT);
  assign alu_operation = op_q;
  assign illegal       = illegal_q;
  assign illegal_count = ill_cnt_q;

  // Stage FSM: accept/reload, MUL countdown, flush squash, output hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE, VALID: begin
          if (accept) begin
            op_q      <= dec_op;
            illegal_q <= dec_illegal;
            if (dec_mul && MUL_MULTI) begin
              state_q <= MUL_WAIT;
              count_q <= MUL_LOAD;
            end else begin
              state_q <= VALID;
            end
          end else if (state_q == VALID && out_ready) begin
            state_q <= IDLE;
          end
        end
        MUL_WAIT: begin
          if (count_q == CNT_W'(1)) begin
            state_q <= VALID;
            count_q <= '0;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  // Saturating count of accepted illegal ops; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_q <= '0;
    end else if (accept && dec_illegal && !(&ill_cnt_q)) begin
      ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: scoreboard of expected
// {illegal, operation} pushed on accept, popped when EX consumes.
module tb_alu_control_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [10:0] opcode_field;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_operation;
  logic        illegal;
  logic        busy;
  logic [7:0]  illegal_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [4:0] sb_q[$];

  alu_control_pipe #(
    .OPCODE_W(11), .OPER_W(4), .MUL_CYCLES(4), .ILL_CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .opcode_field  (opcode_field),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_operation (alu_operation),
    .illegal       (illegal),
    .busy          (busy),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: returns {illegal, operation}
  function automatic logic [4:0] model(input logic [1:0] a, input logic [10:0] o);
    logic [9:0] io;
    io = o[10:1];
    if (a == 2'b00) return 5'b0_0010;
    if (a == 2'b01) return 5'b0_0111;
    if (a == 2'b10) begin
      if (o == 11'b10001011000) return 5'b0_0010;
      if (o == 11'b11001011000) return 5'b0_0110;
      if (o == 11'b10001010000) return 5'b0_0000;
      if (o == 11'b10101010000) return 5'b0_0001;
      if (o == 11'b11001010000) return 5'b0_0011;
      if (o == 11'b11010011011) return 5'b0_1000;
      if (o == 11'b11010011010) return 5'b0_1001;
      if (o == 11'b10011011000) return 5'b0_1010;
      return 5'b1_1111;
    end
    if (io == 10'b1001000100) return 5'b0_0010;
    if (io == 10'b1101000100) return 5'b0_0110;
    if (io == 10'b1001001000) return 5'b0_0000;
    if (io == 10'b1011001000) return 5'b0_0001;
    return 5'b1_1111;
  endfunction

  // Scoreboard: pop on consume, drop on flush, push on accept
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_op", {28'd0, alu_operation}, {28'd0, e[3:0]});
          chk("sb_ill", {31'd0, illegal}, {31'd0, e[4]});
          $display("txn: op=%b ill=%b cnt=%0d", alu_operation, illegal, illegal_count);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(model(alu_op, opcode_field));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [10:0] o);
    in_valid     = 1'b1;
    alu_op       = a;
    opcode_field = o;
  endtask

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] MUL  = 11'b10011011000;
  localparam logic [10:0] ORRI = 11'b10110010000;
  localparam logic [10:0] BAD  = 11'b11111111111;

  logic [1:0]  tbl_a [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
  logic [10:0] tbl_o [9] = '{11'b10001010000, 11'b10101010000, 11'b11001010000,
                             11'b11010011011, 11'b11010011010, 11'b10010001001,
                             11'b11010001000, 11'b10010010000, 11'b00000000000};

  initial begin
    logic [4:0] m;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; opcode_field = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_op", {28'd0, alu_operation}, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ill_cnt", {24'd0, illegal_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_in_ready", {31'd0, in_ready}, 1);

    // ADD, latency 1
    drive(2'b10, ADD); step(); in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 1);
    chk("add_op", {28'd0, alu_operation}, 4'b0010);
    chk("add_ill", {31'd0, illegal}, 0);
    step();
    chk("add_idle", {31'd0, out_valid}, 0);

    // MUL, 4 edges to out_valid
    drive(2'b10, MUL); step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy", {31'd0, busy}, 1);
      chk("mul_in_ready", {31'd0, in_ready}, 0);
      chk("mul_no_valid", {31'd0, out_valid}, 0);
      step();
    end
    chk("mul_valid", {31'd0, out_valid}, 1);
    chk("mul_op", {28'd0, alu_operation}, 4'b1010);
    chk("mul_busy_done", {31'd0, busy}, 0);
    step();

    // Back-to-back SUB, ORRI, ALUop 01
    drive(2'b10, SUB); step();
    chk("b2b_sub", {28'd0, alu_operation}, 4'b0110);
    chk("b2b_rdy1", {31'd0, in_ready}, 1);
    drive(2'b11, ORRI); step();
    chk("b2b_orri", {28'd0, alu_operation}, 4'b0001);
    chk("b2b_rdy2", {31'd0, in_ready}, 1);
    drive(2'b01, BAD); step();
    chk("b2b_cbz", {28'd0, alu_operation}, 4'b0111);
    chk("b2b_valid", {31'd0, out_valid}, 1);
    in_valid = 1'b0; step();

    // Remaining decode table, back-to-back
    for (int i = 0; i < 9; i++) begin
      drive(tbl_a[i], tbl_o[i]); step();
      m = model(tbl_a[i], tbl_o[i]);
      chk("tbl_op", {28'd0, alu_operation}, {28'd0, m[3:0]});
      chk("tbl_ill", {31'd0, illegal}, {31'd0, m[4]});
    end
    in_valid = 1'b0; step();

    // Illegal opcode and counter saturation
    drive(2'b10, BAD); step();
    chk("ill_op", {28'd0, alu_operation}, 4'b1111);
    chk("ill_flag", {31'd0, illegal}, 1);
    chk("ill_cnt1", {24'd0, illegal_count}, 1);
    for (int i = 0; i < 300; i++) begin
      if (i[0]) drive(2'b11, BAD); else drive(2'b10, BAD);
      step();
    end
    in_valid = 1'b0;
    chk("ill_cnt_sat", {24'd0, illegal_count}, 255);
    step();

    // Flush during MUL_WAIT
    drive(2'b10, MUL); step();
    chk("fl_busy", {31'd0, busy}, 1);
    flush = 1'b1; drive(2'b10, ADD); #1;
    chk("fl_in_ready", {31'd0, in_ready}, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 0);
    chk("fl_busy_clr", {31'd0, busy}, 0);
    chk("fl_cnt_kept", {24'd0, illegal_count}, 255);
    step();
    chk("fl_no_accept", {31'd0, out_valid}, 0);

    // Backpressure hold for 5 cycles
    out_ready = 1'b0;
    drive(2'b10, ADD); step();
    drive(2'b10, SUB);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_op", {28'd0, alu_operation}, 4'b0010);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("hold_release", {31'd0, out_valid}, 0);

    // Async reset mid-MUL
    drive(2'b10, MUL); step(); in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("amr_out_valid", {31'd0, out_valid}, 0);
    chk("amr_busy", {31'd0, busy}, 0);
    chk("amr_op", {28'd0, alu_operation}, 0);
    chk("amr_ill", {31'd0, illegal}, 0);
    chk("amr_cnt", {24'd0, illegal_count}, 0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("amr_no_residual", {31'd0, out_valid}, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
